// File: rtl/stp_wrapper.sv
// Serial-to-parallel word shifter for the FFT front end: keeps the last
// NUM_WORDS strobed samples, oldest at index 0 and newest at index NUM_WORDS-1.
module stp_wrapper #(
    parameter int unsigned NUM_WORDS = 48,
    parameter int unsigned WORD_W    = 16
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                it_cnt_strobe,
    input  logic [WORD_W-1:0]                   serial_in,
    output logic [NUM_WORDS-1:0][WORD_W-1:0]    data_par
);

    logic [NUM_WORDS-1:0][WORD_W-1:0] regs;

    // Each stage takes its upper neighbour, so the oldest word drops off index 0
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            regs <= '0;
        end else if (it_cnt_strobe) begin
            regs <= {serial_in, regs[NUM_WORDS-1:1]};
        end
    end

    assign data_par = regs;

endmodule

// File: tb/tb_stp_wrapper.sv
// Self-checking bench for stp_wrapper: a shadow window model feeds a scoreboard
// queue every cycle, plus targeted word checks for each scenario.
module tb_stp_wrapper;

    localparam int unsigned NW = 48;
    localparam int unsigned WW = 16;

    typedef logic [NW-1:0][WW-1:0] vec_t;

    logic              clk;
    logic              n_rst;
    logic              it_cnt_strobe;
    logic [WW-1:0]     serial_in;
    vec_t              data_par;

    vec_t              model;
    vec_t              sb[$];
    int                checks;
    int                failures;

    stp_wrapper #(
        .NUM_WORDS(NW),
        .WORD_W   (WW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .it_cnt_strobe(it_cnt_strobe),
        .serial_in    (serial_in),
        .data_par     (data_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the expected window is queued when driven and
    // compared just after the rising edge.
    task automatic drive_cycle(input logic stb, input logic [WW-1:0] d);
        vec_t exp_v;
        @(negedge clk);
        it_cnt_strobe = stb;
        serial_in     = d;
        if (stb === 1'b1) model = {d, model[NW-1:1]};
        sb.push_back(model);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (data_par !== exp_v) begin
            failures++;
            for (int i = 0; i < NW; i++) begin
                if (data_par[i] !== exp_v[i]) begin
                    $display("FAIL scoreboard word[%0d] got=%h exp=%h t=%0t",
                             i, data_par[i], exp_v[i], $time);
                    break;
                end
            end
        end
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        it_cnt_strobe = 1'b0;
        #2;
        n_rst = 1'b0;
        model = '0;
        #1;
        checks++;
        if (data_par !== vec_t'('0)) begin
            failures++;
            $display("FAIL reset_async_clear got_word0=%h got_word47=%h exp=0000",
                     data_par[0], data_par[NW-1]);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst         = 1'b0;
        it_cnt_strobe = 1'b0;
        serial_in     = '0;
        model         = '0;
        #12;
        checks++;
        if (data_par !== vec_t'('0)) begin
            failures++;
            $display("FAIL reset_initial got_word0=%h exp=0000", data_par[0]);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, WW'($urandom));
        // Held reset must keep zeros across a clock edge even with strobe high
        @(negedge clk);
        n_rst = 1'b0;
        it_cnt_strobe = 1'b1;
        serial_in = 16'hDEAD;
        model = '0;
        #1;
        checks++;
        if (data_par !== vec_t'('0)) begin
            failures++;
            $display("FAIL reset_async_clear got_word47=%h exp=0000", data_par[NW-1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_par !== vec_t'('0)) begin
            failures++;
            $display("FAIL reset_held got_word47=%h exp=0000", data_par[NW-1]);
        end
        @(negedge clk);
        it_cnt_strobe = 1'b0;
        n_rst = 1'b1;
    endtask

    task automatic test_full_load();
        drive_cycle(1'b0, 16'h0000);
        for (int i = 0; i < NW; i++) drive_cycle(1'b1, WW'(i));
        drive_cycle(1'b0, 16'h0000);
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (data_par[i] !== WW'(i)) begin
                failures++;
                $display("FAIL full_load word[%0d] got=%h exp=%h", i, data_par[i], WW'(i));
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 16'hFFFF);
        drive_cycle(1'b0, 16'hxxxx);
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (data_par[i] !== WW'(i)) begin
                failures++;
                $display("FAIL hold word[%0d] got=%h exp=%h", i, data_par[i], WW'(i));
            end
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 16'hAAAA);
        drive_cycle(1'b1, 16'hBBBB);
        drive_cycle(1'b0, 16'h0000);
        checks++;
        if (data_par[0] !== 16'h0002) begin
            failures++;
            $display("FAIL overflow_w0 got=%h exp=0002", data_par[0]);
        end
        checks++;
        if (data_par[45] !== 16'h002F) begin
            failures++;
            $display("FAIL overflow_w45 got=%h exp=002f", data_par[45]);
        end
        checks++;
        if (data_par[46] !== 16'hAAAA) begin
            failures++;
            $display("FAIL overflow_w46 got=%h exp=aaaa", data_par[46]);
        end
        checks++;
        if (data_par[47] !== 16'hBBBB) begin
            failures++;
            $display("FAIL overflow_w47 got=%h exp=bbbb", data_par[47]);
        end
    endtask

    task automatic test_gapped();
        async_reset_pulse();
        drive_cycle(1'b1, 16'h1234);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h9999);
        drive_cycle(1'b1, 16'h5678);
        for (int i = 0; i < NW; i++) begin
            logic [WW-1:0] e;
            e = (i == 46) ? 16'h1234 : (i == 47) ? 16'h5678 : 16'h0000;
            checks++;
            if (data_par[i] !== e) begin
                failures++;
                $display("FAIL gapped word[%0d] got=%h exp=%h", i, data_par[i], e);
            end
        end
    endtask

    task automatic test_midfill_reset();
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, WW'(16'h0100 + i));
        async_reset_pulse();
        drive_cycle(1'b1, 16'h00C0);
        for (int i = 0; i < NW; i++) begin
            logic [WW-1:0] e;
            e = (i == 47) ? 16'h00C0 : 16'h0000;
            checks++;
            if (data_par[i] !== e) begin
                failures++;
                $display("FAIL midfill_reset word[%0d] got=%h exp=%h", i, data_par[i], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 100; i++) drive_cycle(1'($urandom_range(0, 3) != 0), WW'($urandom));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_load();
        test_hold();
        test_overflow();
        test_gapped();
        test_midfill_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
